// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder -- behavioural-but-synthesizable model of one x16 SDRAM
// device (MT48LC16M16 command subset), sitting on the device side of the pins.
//
// Ports
//   clk, reset_n        sole clock; synchronous active-low reset
//   sdram_cke/ncs       clock enable / chip select (inactive => NOP)
//   sdram_nras/ncas/nwe command strobes
//   sdram_ba, sdram_a   bank and multiplexed address (A10 = auto/all precharge)
//   sdram_dqml/dqmh     byte-lane masks (write mask, read output mask)
//   sdram_dq_i          write data from the controller
//   sdram_dq_o/dq_oe    read data and its drive enable
//   mode_reg            last accepted LOAD_MODE value
//   init_done           set by the first accepted LOAD_MODE
//   refresh_count       accepted AUTO_REFRESH commands, saturating
//   err/err_code        sticky violation flag / code of the latest violation
// -----------------------------------------------------------------------------

// One bank: IDLE/OPEN state plus the row latched by ACTIVE.
module sdram_bank #(
    parameter int ROW_BITS = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                open_i,
    input  logic                close_i,
    input  logic [ROW_BITS-1:0] row_i,
    output logic                open_o,
    output logic [ROW_BITS-1:0] row_o
);
    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} bank_state_e;

    bank_state_e         state_q;
    logic [ROW_BITS-1:0] row_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (open_i) begin
                    state_q <= OPEN;
                    row_q   <= row_i;
                end
                OPEN: if (close_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign open_o = (state_q == OPEN);
    assign row_o  = row_q;
endmodule

module sdram_responder #(
    parameter int ADDR_BITS = 14,
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdram_cke,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic [12:0] mode_reg,
    output logic        init_done,
    output logic [15:0] refresh_count,
    output logic        err,
    output logic [2:0]  err_code
);
    localparam int IDX_FULL = 2 + ROW_BITS + COL_BITS;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    cmd_e cmd;
    assign cmd = (sdram_cke && !sdram_ncs) ? cmd_e'({sdram_nras, sdram_ncas, sdram_nwe})
                                           : CMD_NOP;

    // ---------------------------------------------------------------- state
    logic [12:0] mode_q;
    logic        init_q;
    logic [15:0] refresh_q;
    logic        err_q;
    logic [2:0]  err_code_q;
    logic [15:0] dq_q;
    logic        oe_q;

    // Read pipeline: stage 0 holds the RAM read launched by READ, stage 1
    // adds the extra cycle needed for CL=3.
    logic        s0_vld_q, s0_cl3_q, s1_vld_q;
    logic [1:0]  s0_dqm_q, s1_dqm_q;
    logic [15:0] rd_data_q, s1_data_q;

    // ---------------------------------------------------------------- banks
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [3:0]          open_req, close_req;

    logic act_ok, rd_ok, wr_ok, ref_ok, lmr_ok, pre_cmd;
    logic [2:0] err_code_d;

    logic bank_hit, any_open, mode_legal, rd_due;
    assign bank_hit   = bank_open[sdram_ba];
    assign any_open   = |bank_open;
    assign mode_legal = (sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) &&
                        (sdram_a[2:0] == 3'd0) && sdram_a[9];
    // A CL=3 read sitting in stage 0 drives the bus from the next edge on.
    assign rd_due     = s0_vld_q && s0_cl3_q;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign open_req[b]  = act_ok && (sdram_ba == 2'(b));
        assign close_req[b] = (pre_cmd && (sdram_a[10] || sdram_ba == 2'(b))) ||
                              ((rd_ok || wr_ok) && sdram_a[10] && sdram_ba == 2'(b));
        sdram_bank #(.ROW_BITS(ROW_BITS)) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .open_i  (open_req[b]),
            .close_i (close_req[b]),
            .row_i   (sdram_a[ROW_BITS-1:0]),
            .open_o  (bank_open[b]),
            .row_o   (bank_row[b])
        );
    end

    // --------------------------------------------------------------- decode
    // Checks are ordered so the lowest applicable violation code wins.
    always_comb begin
        act_ok     = 1'b0;
        rd_ok      = 1'b0;
        wr_ok      = 1'b0;
        ref_ok     = 1'b0;
        lmr_ok     = 1'b0;
        pre_cmd    = 1'b0;
        err_code_d = 3'd0;
        case (cmd)
            CMD_ACT: if (bank_hit)        err_code_d = 3'd1;
                     else if (!init_q)    err_code_d = 3'd3;
                     else                 act_ok     = 1'b1;
            CMD_RD:  if (!bank_hit)       err_code_d = 3'd2;
                     else if (!init_q)    err_code_d = 3'd3;
                     else                 rd_ok      = 1'b1;
            CMD_WR:  if (!bank_hit)       err_code_d = 3'd2;
                     else if (!init_q)    err_code_d = 3'd3;
                     else if (rd_due)     err_code_d = 3'd6;
                     else                 wr_ok      = 1'b1;
            CMD_PRE:                      pre_cmd    = 1'b1;
            CMD_REF: if (any_open)        err_code_d = 3'd4;
                     else                 ref_ok     = 1'b1;
            CMD_LMR: if (any_open)        err_code_d = 3'd4;
                     else if (!mode_legal) err_code_d = 3'd5;
                     else                 lmr_ok     = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ RAM
    logic [IDX_FULL-1:0]  idx_full;
    logic [ADDR_BITS-1:0] mem_idx;
    logic                 unused_idx_bits;
    assign idx_full        = {sdram_ba, bank_row[sdram_ba], sdram_a[COL_BITS-1:0]};
    assign mem_idx         = idx_full[ADDR_BITS-1:0];
    assign unused_idx_bits = ^idx_full;

    logic [7:0] mem_lo [2**ADDR_BITS];
    logic [7:0] mem_hi [2**ADDR_BITS];

    // No reset here: contents survive reset_n.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok) begin
            if (!sdram_dqml) mem_lo[mem_idx] <= sdram_dq_i[7:0];
            if (!sdram_dqmh) mem_hi[mem_idx] <= sdram_dq_i[15:8];
        end
        rd_data_q <= {mem_hi[mem_idx], mem_lo[mem_idx]};
        s1_data_q <= rd_data_q;
    end

    function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] m);
        return {m[1] ? 8'h00 : d[15:8], m[0] ? 8'h00 : d[7:0]};
    endfunction

    logic [15:0] dq_d;
    logic        oe_d;
    always_comb begin
        dq_d = '0;
        oe_d = 1'b0;
        if (s1_vld_q) begin
            dq_d = lane_mask(s1_data_q, s1_dqm_q);
            oe_d = 1'b1;
        end else if (s0_vld_q && !s0_cl3_q) begin
            dq_d = lane_mask(rd_data_q, s0_dqm_q);
            oe_d = 1'b1;
        end
    end

    // ------------------------------------------------------ control/status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q     <= '0;
            init_q     <= 1'b0;
            refresh_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            s0_vld_q   <= 1'b0;
            s0_cl3_q   <= 1'b0;
            s0_dqm_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_dqm_q   <= '0;
        end else begin
            if (err_code_d != 3'd0) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_d;
            end
            if (lmr_ok) begin
                mode_q <= sdram_a;
                init_q <= 1'b1;
            end
            if (ref_ok && refresh_q != 16'hFFFF) refresh_q <= refresh_q + 16'd1;
            // CL and DQM travel with the read so later commands cannot alter it.
            s0_vld_q <= rd_ok;
            s0_cl3_q <= (mode_q[6:4] == 3'd3);
            s0_dqm_q <= {sdram_dqmh, sdram_dqml};
            s1_vld_q <= s0_vld_q && s0_cl3_q;
            s1_dqm_q <= s0_dqm_q;
            dq_q     <= dq_d;
            oe_q     <= oe_d;
        end
    end

    assign sdram_dq_o    = dq_q;
    assign sdram_dq_oe   = oe_q;
    assign mode_reg      = mode_q;
    assign init_done     = init_q;
    assign refresh_count = refresh_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
endmodule

// File: tb/tb_sdram_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_responder -- directed scenarios followed by random command traffic,
// all checked every cycle against a transaction-level model: a dictionary of
// bytes for the array and a table of "edge -> expected bus word" for reads.
// -----------------------------------------------------------------------------
module tb_sdram_responder;
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1, ncs = 1'b0;
    logic        nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic        dqml = 1'b0, dqmh = 1'b0;
    logic [15:0] dq_i = '0;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [12:0] mode_reg;
    logic        init_done;
    logic [15:0] refresh_count;
    logic        err;
    logic [2:0]  err_code;

    sdram_responder dut (
        .clk(clk), .reset_n(reset_n), .sdram_cke(cke), .sdram_ncs(ncs),
        .sdram_nras(nras), .sdram_ncas(ncas), .sdram_nwe(nwe), .sdram_ba(ba),
        .sdram_a(a), .sdram_dqml(dqml), .sdram_dqmh(dqmh), .sdram_dq_i(dq_i),
        .sdram_dq_o(dq_o), .sdram_dq_oe(dq_oe), .mode_reg(mode_reg),
        .init_done(init_done), .refresh_count(refresh_count), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ------------------------------------------------------------- model
    bit          m_open [4];
    int          m_row  [4];
    logic [12:0] m_mode;
    bit          m_init;
    int          m_ref;
    bit          m_err;
    int          m_code;
    logic [7:0]  m_lo [int];
    logic [7:0]  m_hi [int];
    logic [16:0] due  [int];   // bit 16: data is known

    function automatic int idx(input int b, input int r, input int c);
        return ((b << 22) | (r << 9) | c) & 'h3FFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_row[b] = 0; end
        m_mode = '0; m_init = 0; m_ref = 0; m_err = 0; m_code = 0;
        due.delete();
    endtask

    // Apply the command sampled at the edge that just happened (edge number cyc).
    task automatic model_edge();
        int e, cl, i, b;
        logic [16:0] v;
        e  = 0;
        cl = int'(m_mode[6:4]);
        b  = int'(ba);
        if (!reset_n) begin model_reset(); return; end
        if (!(cke && !ncs)) return;
        case ({nras, ncas, nwe})
            C_ACT: if (m_open[b]) e = 1;
                   else if (!m_init) e = 3;
                   else begin m_open[b] = 1; m_row[b] = int'(a); end
            C_RD:  if (!m_open[b]) e = 2;
                   else if (!m_init) e = 3;
                   else begin
                       i = idx(b, m_row[b], int'(a[8:0]));
                       v[16] = 1'b1;
                       if (dqml) v[7:0] = 8'h00;
                       else if (m_lo.exists(i)) v[7:0] = m_lo[i];
                       else begin v[7:0] = 8'h00; v[16] = 1'b0; end
                       if (dqmh) v[15:8] = 8'h00;
                       else if (m_hi.exists(i)) v[15:8] = m_hi[i];
                       else begin v[15:8] = 8'h00; v[16] = 1'b0; end
                       due[cyc + cl - 1] = v;
                       if (a[10]) m_open[b] = 0;
                   end
            C_WR:  if (!m_open[b]) e = 2;
                   else if (!m_init) e = 3;
                   else if (due.exists(cyc + 1)) e = 6;
                   else begin
                       i = idx(b, m_row[b], int'(a[8:0]));
                       if (!dqml) m_lo[i] = dq_i[7:0];
                       if (!dqmh) m_hi[i] = dq_i[15:8];
                       if (a[10]) m_open[b] = 0;
                   end
            C_PRE: if (a[10]) for (int k = 0; k < 4; k++) m_open[k] = 0;
                   else m_open[b] = 0;
            C_REF: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e = 4;
                   else if (m_ref < 65535) m_ref++;
            C_LMR: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e = 4;
                   else if (!((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0 && a[9])) e = 5;
                   else begin m_mode = a; m_init = 1; end
            default: ;
        endcase
        if (e != 0) begin m_err = 1; m_code = e; end
    endtask

    task automatic check_all();
        bit exp_oe;
        chk("init_done", init_done, m_init);
        chk("mode_reg", mode_reg, m_mode);
        chk("refresh_count", refresh_count, m_ref);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        exp_oe = due.exists(cyc);
        chk("dq_oe", dq_oe, exp_oe);
        if (exp_oe) begin
            if (due[cyc][16]) chk("dq_o", dq_o, due[cyc][15:0]);
            due.delete(cyc);
        end else begin
            chk("dq_o_idle", dq_o, 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] av,
                       input logic [1:0] m, input logic [15:0] d);
        {nras, ncas, nwe} = c;
        ba = b; a = av; {dqmh, dqml} = m; dq_i = d;
        step();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    logic [12:0] lmr_tab [6];
    int r, rb, rrow, rcol;
    logic ra10;
    logic [1:0] rm;

    initial begin
        lmr_tab = '{13'h220, 13'h230, 13'h210, 13'h221, 13'h020, 13'h240};
        model_reset();

        // reset state
        reset_n = 1'b0;
        nop(2);
        chk("rst_oe", dq_oe, 0); chk("rst_err", err, 0); chk("rst_init", init_done, 0);
        reset_n = 1'b1;

        // init sequence
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        for (int i = 0; i < 8; i++) cmd(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
        cmd(C_LMR, 2'd0, 13'h220, 2'b00, 16'h0);
        chk("init_done1", init_done, 1); chk("init_mode", mode_reg, 13'h220);
        chk("init_refcnt", refresh_count, 8); chk("init_err", err, 0);

        // CL=2 write with auto-precharge, reopen, read
        cmd(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        cmd(C_WR,  2'd1, 13'h403, 2'b00, 16'hA55A);
        cmd(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        cmd(C_RD,  2'd1, 13'h003, 2'b00, 16'h0);
        chk("cl2_k_oe", dq_oe, 0);
        nop(1); chk("cl2_k1_oe", dq_oe, 1); chk("cl2_k1_data", dq_o, 16'hA55A);
        nop(1); chk("cl2_k2_oe", dq_oe, 0);

        // byte masks
        cmd(C_WR, 2'd1, 13'd7, 2'b00, 16'h1234);
        cmd(C_WR, 2'd1, 13'd7, 2'b10, 16'hFFFF);
        cmd(C_RD, 2'd1, 13'd7, 2'b00, 16'h0);
        nop(1); chk("mask_wr", dq_o, 16'h12FF);
        nop(1);
        cmd(C_RD, 2'd1, 13'd7, 2'b01, 16'h0);
        nop(1); chk("mask_rd", dq_o, 16'h1200);
        nop(1);

        // CL=3 back-to-back reads
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        cmd(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
        cmd(C_ACT, 2'd0, 13'd2, 2'b00, 16'h0);
        cmd(C_WR,  2'd0, 13'd0, 2'b00, 16'h1111);
        cmd(C_WR,  2'd0, 13'd1, 2'b00, 16'h2222);
        cmd(C_RD,  2'd0, 13'd0, 2'b00, 16'h0);
        cmd(C_RD,  2'd0, 13'd1, 2'b00, 16'h0);
        chk("cl3_k1_oe", dq_oe, 0);
        nop(1); chk("cl3_k2_oe", dq_oe, 1); chk("cl3_first", dq_o, 16'h1111);
        nop(1); chk("cl3_k3_oe", dq_oe, 1); chk("cl3_second", dq_o, 16'h2222);
        nop(1); chk("cl3_k4_oe", dq_oe, 0);

        // protocol violations
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        cmd(C_RD,  2'd2, 13'd0, 2'b00, 16'h0);
        chk("rd_idle_err", err, 1); chk("rd_idle_code", err_code, 2);
        nop(3); chk("rd_idle_oe", dq_oe, 0);
        cmd(C_ACT, 2'd0, 13'd2, 2'b00, 16'h0);
        cmd(C_ACT, 2'd0, 13'd2, 2'b00, 16'h0);
        chk("act_twice_code", err_code, 1);
        cmd(C_RD,  2'd0, 13'd0, 2'b00, 16'h0);
        cmd(C_WR,  2'd0, 13'd0, 2'b00, 16'hDEAD);
        chk("wr_contention_code", err_code, 6);
        nop(3);
        cmd(C_RD,  2'd0, 13'd0, 2'b00, 16'h0);
        nop(2); chk("wr_contention_ignored", dq_o, 16'h1111);
        nop(1);

        // reset with a CL=3 read in flight
        cmd(C_RD, 2'd0, 13'd0, 2'b00, 16'h0);
        reset_n = 1'b0;
        nop(1);
        reset_n = 1'b1;
        chk("rst2_oe", dq_oe, 0); chk("rst2_err", err, 0); chk("rst2_code", err_code, 0);
        chk("rst2_mode", mode_reg, 0); chk("rst2_ref", refresh_count, 0);
        nop(3); chk("rst2_oe_late", dq_oe, 0);
        cmd(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
        cmd(C_ACT, 2'd0, 13'd2, 2'b00, 16'h0);
        cmd(C_RD,  2'd0, 13'd0, 2'b00, 16'h0);
        nop(2); chk("ram_kept", dq_o, 16'h1111); chk("ram_kept_oe", dq_oe, 1);
        nop(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r    = $urandom_range(0, 199);
            rb   = $urandom_range(0, 3);
            rrow = $urandom_range(0, 3);
            rcol = $urandom_range(0, 7);
            ra10 = ($urandom_range(0, 3) == 0);
            rm   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cke = 1'b1; ncs = 1'b0; reset_n = 1'b1;
            if (r < 40)       cmd(C_ACT, 2'(rb), 13'(rrow), rm, 16'h0);
            else if (r < 80)  cmd(C_RD,  2'(rb), {2'b00, ra10, 1'b0, 9'(rcol)}, rm, 16'h0);
            else if (r < 115) cmd(C_WR,  2'(rb), {2'b00, ra10, 1'b0, 9'(rcol)}, rm, 16'($urandom));
            else if (r < 135) cmd(C_PRE, 2'(rb), {2'b00, ra10, 10'd0}, rm, 16'h0);
            else if (r < 141) cmd(C_REF, 2'(rb), 13'd0, rm, 16'h0);
            else if (r < 147) cmd(C_LMR, 2'd0, lmr_tab[$urandom_range(0, 5)], rm, 16'h0);
            else if (r < 152) begin cke = 1'b0; cmd(3'($urandom_range(0, 7)), 2'(rb), 13'(rcol), rm, 16'h0); end
            else if (r < 157) begin ncs = 1'b1; cmd(3'($urandom_range(0, 7)), 2'(rb), 13'(rcol), rm, 16'h0); end
            else if (r < 159) begin reset_n = 1'b0; cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0); end
            else if (r < 163) cmd(C_BST, 2'(rb), 13'd0, rm, 16'h0);
            else              cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
        end
        cke = 1'b1; ncs = 1'b0; reset_n = 1'b1;
        nop(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
